// File: rtl/branch_resolve_pkg.sv
// ---------------------------------------------------------------------------
// branch_resolve_pkg
//   Shared RV32 opcode/funct3 constants for conditional branches and a helper
//   that maps (funct3, comparator flags) to the resolved branch outcome.
//   Every branch-decoding file imports this package, so the encodings exist
//   in exactly one place.
//
//   Contents:
//     OPC_BRANCH            - 7-bit major opcode of conditional branches
//     F3_BEQ .. F3_BGEU     - funct3 encodings of the six legal branches
//     brOutcome_t           - {valid, taken} result of decoding one branch
//     resolveBranch()       - funct3 + BrLT/BrEq -> brOutcome_t
// ---------------------------------------------------------------------------
package branch_resolve_pkg;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // valid=0 marks the reserved funct3 codes (010/011): such an instruction
    // is treated as not taken and must neither train the BHT nor redirect.
    typedef struct packed {
        logic valid;
        logic taken;
    } brOutcome_t;

    // The comparator already picks signed/unsigned compare for BrLT, so the
    // signed and unsigned flavours share the same flag here.
    function automatic brOutcome_t resolveBranch(input logic [2:0] funct3,
                                                 input logic       brLT,
                                                 input logic       brEq);
        brOutcome_t res;
        res.valid = 1'b1;
        res.taken = 1'b0;
        case (funct3)
            F3_BEQ:  res.taken = brEq;
            F3_BNE:  res.taken = !brEq;
            F3_BLT:  res.taken = brLT;
            F3_BGE:  res.taken = !brLT;
            F3_BLTU: res.taken = brLT;
            F3_BGEU: res.taken = !brLT;
            default: res.valid = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/branch_resolve_bht_2bit.sv
// ---------------------------------------------------------------------------
// bht_2bit
//   Branch history table of 2^IDX_W two-bit saturating counters.
//   One combinational read port (prediction = counter MSB) and one
//   synchronous write port that nudges a counter towards taken / not taken.
//   Reset is asynchronous and puts every counter in the weakly-not-taken
//   state (2'b01).
//
//   Ports:
//     clk      in   clock, counters update on the rising edge
//     rst      in   async active-high reset, all counters -> 2'b01
//     rdIdx    in   [IDX_W] read index (fetch side)
//     rdTaken  out  prediction for rdIdx (MSB of counter)
//     wrEn     in   train the counter at wrIdx this cycle
//     wrIdx    in   [IDX_W] write index (execute side)
//     wrTaken  in   1 = increment (saturate at 3), 0 = decrement (saturate at 0)
// ---------------------------------------------------------------------------
module bht_2bit #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rdIdx,
    output logic             rdTaken,
    input  logic             wrEn,
    input  logic [IDX_W-1:0] wrIdx,
    input  logic             wrTaken
);

    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0][1:0] ctr;
    logic [1:0]            wrOld;
    logic [1:0]            wrNew;

    // Read straight from the register array: a same-cycle write to the same
    // entry is only visible after the edge, giving read-before-write.
    assign rdTaken = ctr[rdIdx][1];

    always_comb begin
        wrOld = ctr[wrIdx];
        wrNew = wrOld;
        if (wrTaken) begin
            if (wrOld != 2'b11) wrNew = wrOld + 2'b01;
        end else begin
            if (wrOld != 2'b00) wrNew = wrOld - 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctr <= {DEPTH{2'b01}};
        end else if (wrEn) begin
            ctr[wrIdx] <= wrNew;
        end
    end

endmodule

// File: rtl/branch_resolve.sv
// ---------------------------------------------------------------------------
// branch_resolve
//   Execute-stage conditional-branch resolution with a 2-bit-counter BHT.
//   Decodes the execute-stage instruction, resolves taken/not-taken from the
//   branch comparator flags, trains the BHT and, when the fetch-time
//   prediction was wrong, issues a registered one-cycle redirect carrying the
//   correct next PC. The instruction sitting in execute while a redirect is
//   out is wrong-path and is squashed.
//
//   Optional feature: define BRANCH_STATS_EN to add the br_count and
//   mispred_count statistic outputs; without it those ports and their
//   counters do not exist.
//
//   Parameters:
//     BHT_IDX_W      log2 of BHT entries (indexed by pc[BHT_IDX_W+1:2])
//   Ports:
//     clk            in   clock
//     rst            in   async active-high reset
//     fetch_pc       in   [32] PC being fetched
//     pred_taken     out  combinational prediction for fetch_pc
//     ex_valid       in   execute-stage instruction valid
//     ex_inst        in   [32] execute-stage instruction word
//     ex_pc          in   [32] execute-stage PC
//     ex_pred_taken  in   prediction made at fetch for this instruction
//     ex_target      in   [32] branch target (ex_pc + B-immediate)
//     BrLT, BrEq     in   comparator flags
//     redirect_valid out  registered one-cycle mispredict flush
//     redirect_pc    out  [32] correct next PC, held between redirects
//     br_count       out  [32] valid branches resolved    (BRANCH_STATS_EN)
//     mispred_count  out  [32] redirects issued           (BRANCH_STATS_EN)
// ---------------------------------------------------------------------------
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int BHT_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    input  logic        ex_valid,
    input  logic [31:0] ex_inst,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_target,
    input  logic        BrLT,
    input  logic        BrEq,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0] br_count,
    output logic [31:0] mispred_count
`endif
);

    brOutcome_t outcome;
    logic       isBranch;
    logic       mispredict;
    logic [31:0] fallThrough;
    logic [31:0] correctPc;

    // Only opcode, funct3 and the index bits of the PCs matter here; the
    // rest is collected so the intent of leaving it unused is explicit.
    logic unusedBits;
    assign unusedBits = ^{ex_inst[31:15], ex_inst[11:7],
                          fetch_pc[31:BHT_IDX_W+2], fetch_pc[1:0]};

    always_comb begin
        outcome     = resolveBranch(ex_inst[14:12], BrLT, BrEq);
        // redirect_valid high means the execute slot holds the shadow of a
        // mispredicted branch: it must not train or redirect.
        isBranch    = ex_valid && !redirect_valid &&
                      (ex_inst[6:0] == OPC_BRANCH) && outcome.valid;
        mispredict  = isBranch && (outcome.taken != ex_pred_taken);
        fallThrough = ex_pc + 32'd4;
        correctPc   = outcome.taken ? ex_target : fallThrough;
    end

    bht_2bit #(
        .IDX_W (BHT_IDX_W)
    ) uBht (
        .clk     (clk),
        .rst     (rst),
        .rdIdx   (fetch_pc[BHT_IDX_W+1:2]),
        .rdTaken (pred_taken),
        .wrEn    (isBranch),
        .wrIdx   (ex_pc[BHT_IDX_W+1:2]),
        .wrTaken (outcome.taken)
    );

    // redirect_valid is a single-cycle pulse by construction: while it is
    // high isBranch is forced low, so mispredict cannot re-arm it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
        end else begin
            redirect_valid <= mispredict;
            if (mispredict) redirect_pc <= correctPc;
        end
    end

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count      <= 32'h0;
            mispred_count <= 32'h0;
        end else begin
            if (isBranch)   br_count      <= br_count + 32'd1;
            if (mispredict) mispred_count <= mispred_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
module tb_branch_resolve;

    localparam int IW = 4;
    localparam int N  = 1 << IW;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic [31:0] ex_inst;
    logic [31:0] ex_pc;
    logic        ex_pred_taken;
    logic [31:0] ex_target;
    logic        BrLT;
    logic        BrEq;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0] br_count;
    logic [31:0] mispred_count;
`endif

    branch_resolve #(.BHT_IDX_W(IW)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_pc       (fetch_pc),
        .pred_taken     (pred_taken),
        .ex_valid       (ex_valid),
        .ex_inst        (ex_inst),
        .ex_pc          (ex_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_target      (ex_target),
        .BrLT           (BrLT),
        .BrEq           (BrEq),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef BRANCH_STATS_EN
        ,
        .br_count       (br_count),
        .mispred_count  (mispred_count)
`endif
    );

    always #5 clk = ~clk;

    int nAsserts = 0;
    int nFail    = 0;

    // Reference model: counter values as plain integers, plus the expected
    // registered outputs and statistics.
    int          mCtr[N];
    logic        mRv;
    logic [31:0] mRpc;
    logic [31:0] mBr;
    logic [31:0] mMis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int idxOf(input logic [31:0] pc);
        return int'(pc[IW+1:2]);
    endfunction

    function automatic logic [31:0] mkBr(input logic [2:0] f3);
        logic [31:0] w;
        w = 32'h0;
        w[6:0]   = 7'b1100011;
        w[14:12] = f3;
        return w;
    endfunction

    // -1: not a resolvable branch; 0/1: actual direction.
    function automatic int modelOutcome(input logic [2:0] f3, input logic lt, input logic eq);
        case (f3)
            3'd0: return eq ? 1 : 0;
            3'd1: return eq ? 0 : 1;
            3'd4, 3'd6: return lt ? 1 : 0;
            3'd5, 3'd7: return lt ? 0 : 1;
            default: return -1;
        endcase
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) mCtr[i] = 1;
        mRv  = 1'b0;
        mRpc = 32'h0;
        mBr  = 32'h0;
        mMis = 32'h0;
    endtask

    task automatic checkRegs(input string tag);
        check({tag, "_rv"},  32'(redirect_valid), 32'(mRv));
        check({tag, "_rpc"}, redirect_pc, mRpc);
`ifdef BRANCH_STATS_EN
        check({tag, "_brc"}, br_count, mBr);
        check({tag, "_mis"}, mispred_count, mMis);
`endif
    endtask

    // One clock cycle: drive, check the combinational prediction, advance
    // the model, clock, check registered outputs.
    task automatic step(input string tag, input logic v, input logic [31:0] inst,
                        input logic [31:0] pc, input logic pt, input logic [31:0] tgt,
                        input logic lt, input logic eq, input logic [31:0] fpc);
        int   out;
        int   i;
        logic nextRv;
        ex_valid = v; ex_inst = inst; ex_pc = pc; ex_pred_taken = pt;
        ex_target = tgt; BrLT = lt; BrEq = eq; fetch_pc = fpc;
        #1;
        check({tag, "_pred"}, 32'(pred_taken), 32'(mCtr[idxOf(fpc)] >= 2));
        out = -1;
        if (v && inst[6:0] == 7'b1100011 && !mRv) out = modelOutcome(inst[14:12], lt, eq);
        nextRv = 1'b0;
        if (out >= 0) begin
            i = idxOf(pc);
            if (out == 1) mCtr[i] = (mCtr[i] == 3) ? 3 : mCtr[i] + 1;
            else          mCtr[i] = (mCtr[i] == 0) ? 0 : mCtr[i] - 1;
            mBr++;
            if (out != int'(pt)) begin
                nextRv = 1'b1;
                mRpc   = (out == 1) ? tgt : pc + 32'd4;
                mMis++;
            end
        end
        mRv = nextRv;
        @(posedge clk);
        #1;
        checkRegs(tag);
    endtask

    task automatic idle(input string tag, input logic [31:0] fpc);
        step(tag, 1'b0, 32'h0000_0013, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, fpc);
    endtask

    initial begin
        logic [31:0] r, pc, inst, fpc;
        logic [2:0]  f3;
        logic        v, pt;

        rst = 1'b1; fetch_pc = 32'h100; ex_valid = 1'b0; ex_inst = 32'h0;
        ex_pc = 32'h0; ex_pred_taken = 1'b0; ex_target = 32'h0; BrLT = 1'b0; BrEq = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state, fetch 0x100 weakly not taken.
        check("rst_pred", 32'(pred_taken), 32'h0);
        check("rst_rv", 32'(redirect_valid), 32'h0);
        check("rst_rpc", redirect_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // BEQ taken, predicted not taken -> redirect to target, counter 01->10.
        step("beq", 1'b1, mkBr(3'b000), 32'h100, 1'b0, 32'h80, 1'b0, 1'b1, 32'h100);
        check("beq_rv_const", 32'(redirect_valid), 32'h1);
        check("beq_rpc_const", redirect_pc, 32'h80);
        idle("beq_after", 32'h100);
        check("beq_pred_const", 32'(pred_taken), 32'h1);
        check("beq_hold_rpc", redirect_pc, 32'h80);

        // BLTU not taken, predicted taken, at top of address space -> wrap.
        step("bltu", 1'b1, mkBr(3'b110), 32'hFFFF_FFFC, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
        check("bltu_rpc_const", redirect_pc, 32'h0);
        idle("bltu_after", 32'hFFFF_FFFC);

        // BNE saturation at 0x200: four taken, then one not taken.
        for (int k = 0; k < 4; k++) begin
            step("bne_t", 1'b1, mkBr(3'b001), 32'h200, 1'(mCtr[idxOf(32'h200)] >= 2),
                 32'h300, 1'b0, 1'b0, 32'h200);
            if (k > 0) check("bne_noredir", 32'(redirect_valid), 32'h0);
            idle("bne_gap", 32'h200);
        end
        check("bne_sat", 32'(mCtr[idxOf(32'h200)]), 32'd3);
        step("bne_nt", 1'b1, mkBr(3'b001), 32'h200, 1'b1, 32'h300, 1'b0, 1'b1, 32'h200);
        idle("bne_nt_after", 32'h200);
        check("bne_stay_taken", 32'(pred_taken), 32'h1);

        // Reserved funct3 and non-branch opcode: no training, no redirect.
        step("f3_010", 1'b1, mkBr(3'b010), 32'h204, 1'b1, 32'h0, 1'b1, 1'b1, 32'h204);
        step("nonbr", 1'b1, 32'h0000_0063 ^ 32'h0000_0040, 32'h204, 1'b1, 32'h0, 1'b1, 1'b1, 32'h204);
        check("nonbr_rv_const", 32'(redirect_valid), 32'h0);

        // Shadow squash: mispredict then a branch in the redirect cycle.
        step("sq_first", 1'b1, mkBr(3'b100), 32'h208, 1'b0, 32'h500, 1'b1, 1'b0, 32'h20C);
        step("sq_shadow", 1'b1, mkBr(3'b000), 32'h20C, 1'b0, 32'h600, 1'b0, 1'b1, 32'h20C);
        check("sq_rv_const", 32'(redirect_valid), 32'h0);
        check("sq_rpc_const", redirect_pc, 32'h500);
        idle("sq_after", 32'h20C);

        // Read-before-write collision on the fetch/update index.
        step("rbw", 1'b1, mkBr(3'b101), 32'h210, 1'b0, 32'h0, 1'b0, 1'b0, 32'h210);
        idle("rbw_after", 32'h210);

        // Randomized traffic over a small PC window to force index reuse.
        for (int k = 0; k < 400; k++) begin
            r  = $urandom();
            f3 = r[2:0];
            v  = r[4:3] != 2'b00;
            if (r[7:5] == 3'b000) begin
                inst = $urandom();
                if (inst[6:0] == 7'b1100011) inst[2] = 1'b1;
            end else begin
                inst = mkBr(f3);
                inst[31:15] = r[31:15];
            end
            pc  = (r[12:8] == 5'd0) ? 32'hFFFF_FFFC : 32'h1000 + (32'($urandom_range(0, N - 1)) << 2);
            fpc = r[13] ? pc : 32'h1000 + (32'($urandom_range(0, N - 1)) << 2);
            pt  = r[14] ? 1'(mCtr[idxOf(pc)] >= 2) : 1'($urandom_range(0, 1));
            step("rand", v, inst, pc, pt, $urandom(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), fpc);
        end

        // Reset in the cycle after a mispredict.
        step("mr_mis", 1'b1, mkBr(3'b000), 32'h100, 1'b0, 32'h900, 1'b0, 1'b1, 32'h100);
        rst = 1'b1;
        #1;
        modelReset();
        check("mr_rv_now", 32'(redirect_valid), 32'h0);
        checkRegs("mr_now");
        @(negedge clk);
        rst = 1'b0;
        idle("mr_idle", 32'h100);
        step("mr_train", 1'b1, mkBr(3'b000), 32'h100, 1'b0, 32'h88, 1'b0, 1'b1, 32'h104);
        idle("mr_after", 32'h100);
        check("mr_ctr01", 32'(pred_taken), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
